seq_divider16: RTL and testbench

Multi-cycle unsigned 16-bit restoring divider. It runs addition in reverse: each iteration does a trial subtraction built from the team's existing ripple-carry adder cell, with the divisor inverted and carry-in forced to 1. It sits beside the datapath ALU as the long-latency divide/remainder unit and produces one quotient bit per clock. A Start/Busy/Done handshake decouples it from the issuing pipeline.

---
 rtl/divider_pkg.sv | 23 ++
 rtl/seq_divider16_if.sv | 25 ++
 rtl/divider_sub_stage.sv | 31 +++
 rtl/seq_divider16.sv | 121 ++++++++++++
 tb/tb_seq_divider16.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default width and the ripple-adder cell used by the trial subtract.
package divider_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divState_e;

    // Counter must hold WIDTH itself, hence one bit more than clog2.
    function automatic int cntWidth(input int width);
        return $clog2(width) + 1;
    endfunction

    // Full-adder cell, returns {carryOut, sum}.
    function automatic logic [1:0] fullAdd(input logic a, input logic b, input logic cin);
        fullAdd = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/seq_divider16_if.sv
// Start/Busy/Done handshake and operand/result bus of the divide unit.
interface seq_divider16_if import divider_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             Start;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             DivByZero;

    modport master (
        output Start, Dividend, Divisor,
        input  Busy, Done, Quotient, Remainder, DivByZero
    );

    modport slave (
        input  Start, Dividend, Divisor,
        output Busy, Done, Quotient, Remainder, DivByZero
    );

endinterface

// File: rtl/divider_sub_stage.sv
// One restoring-division step: WIDTH+1-bit trial subtract trial - {0,divisor}
// done as a ripple add of the inverted divisor with carry-in forced high.
module divider_sub_stage import divider_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   trial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   diff,
    output logic             noBorrow
);

    logic [WIDTH:0] divisorInv;
    logic [1:0]     faOut;
    logic           carry;

    assign divisorInv = ~{1'b0, divisor};

    // Ripple-carry chain; the final carry-out is the no-borrow flag.
    always_comb begin
        diff  = {(WIDTH + 1){1'b0}};
        carry = 1'b1;
        faOut = 2'b00;
        for (int i = 0; i <= WIDTH; i++) begin
            faOut   = fullAdd(trial[i], divisorInv[i], carry);
            diff[i] = faOut[0];
            carry   = faOut[1];
        end
        noBorrow = carry;
    end

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with a Start/Busy/Done handshake toward the issuing pipeline.
module seq_divider16 import divider_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               Clk,
    input  logic               ResetN,
    seq_divider16_if.slave     bus
);

    localparam int CntW = cntWidth(WIDTH);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntOne  = {{(CntW - 1){1'b0}}, 1'b1};

    divState_e        stateR, stateNext;
    logic [WIDTH:0]   remR, remNext;
    logic [WIDTH-1:0] qR, qNext;
    logic [WIDTH-1:0] dR, dNext;
    logic [CntW-1:0]  cntR, cntNext;
    logic             busyR, doneR, dbzR, dbzNext;
    logic [WIDTH-1:0] quotR, quotNext;
    logic [WIDTH-1:0] remOutR, remOutNext;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             noBorrow;
    logic             unusedRemTop;

    // Restoring keeps R below D, so R's top bit never feeds the next shift.
    assign unusedRemTop = remR[WIDTH];
    assign trial        = {remR[WIDTH-1:0], qR[WIDTH-1]};

    divider_sub_stage #(.WIDTH(WIDTH)) subStage (
        .trial    (trial),
        .divisor  (dR),
        .diff     (diff),
        .noBorrow (noBorrow)
    );

    // Next-state, datapath and result-register update.
    always_comb begin
        stateNext  = stateR;
        remNext    = remR;
        qNext      = qR;
        dNext      = dR;
        cntNext    = cntR;
        quotNext   = quotR;
        remOutNext = remOutR;
        dbzNext    = dbzR;
        case (stateR)
            IDLE, DONE: begin
                if (bus.Start) begin
                    if (bus.Divisor != {WIDTH{1'b0}}) begin
                        dNext     = bus.Divisor;
                        qNext     = bus.Dividend;
                        remNext   = {(WIDTH + 1){1'b0}};
                        cntNext   = CntLoad;
                        dbzNext   = 1'b0;
                        stateNext = RUN;
                    end else begin
                        quotNext   = {WIDTH{1'b1}};
                        remOutNext = bus.Dividend;
                        dbzNext    = 1'b1;
                        stateNext  = DONE;
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            RUN: begin
                remNext = noBorrow ? diff : trial;
                qNext   = {qR[WIDTH-2:0], noBorrow};
                cntNext = cntR - CntOne;
                if (cntR == CntOne) begin
                    quotNext   = qNext;
                    remOutNext = remNext[WIDTH-1:0];
                    stateNext  = DONE;
                end else begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            stateR  <= IDLE;
            remR    <= {(WIDTH + 1){1'b0}};
            qR      <= {WIDTH{1'b0}};
            dR      <= {WIDTH{1'b0}};
            cntR    <= {CntW{1'b0}};
            busyR   <= 1'b0;
            doneR   <= 1'b0;
            dbzR    <= 1'b0;
            quotR   <= {WIDTH{1'b0}};
            remOutR <= {WIDTH{1'b0}};
        end else begin
            stateR  <= stateNext;
            remR    <= remNext;
            qR      <= qNext;
            dR      <= dNext;
            cntR    <= cntNext;
            busyR   <= (stateNext == RUN);
            doneR   <= (stateNext == DONE);
            dbzR    <= dbzNext;
            quotR   <= quotNext;
            remOutR <= remOutNext;
        end
    end

    assign bus.Busy      = busyR;
    assign bus.Done      = doneR;
    assign bus.DivByZero = dbzR;
    assign bus.Quotient  = quotR;
    assign bus.Remainder = remOutR;

endmodule

// File: tb/tb_seq_divider16.sv
// Directed self-checking bench for seq_divider16: latency, results,
// divide-by-zero, ignored Start in RUN, mid-run reset and back-to-back.
module tb_seq_divider16;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_divider16_if #(.WIDTH(16)) bus ();

    seq_divider16 #(.WIDTH(16)) dut (
        .Clk    (clk),
        .ResetN (rstN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands one cycle; returns #1 after the accepting edge.
    task automatic startOp(input logic [15:0] dvd, input logic [15:0] dvs);
        bus.Start    = 1'b1;
        bus.Dividend = dvd;
        bus.Divisor  = dvs;
        @(posedge clk);
        #1;
        bus.Start    = 1'b0;
        bus.Dividend = 16'h0000;
        bus.Divisor  = 16'h0000;
    endtask

    // Called #1 after the accepting edge; counts cycles up to Done.
    task automatic waitDone(input string tag, input logic [15:0] expQ, input logic [15:0] expR,
                            input logic expDbz, input int expLat, input int pokeAt,
                            input bit checkPulseEnd);
        int n = 1;
        int busyCnt = 0;
        while (bus.Done !== 1'b1 && n < 40) begin
            if (bus.Busy === 1'b1) busyCnt++;
            if (n == pokeAt) begin
                bus.Start    = 1'b1;
                bus.Dividend = 16'd50;
                bus.Divisor  = 16'd5;
            end
            @(posedge clk);
            #1;
            if (n == pokeAt) begin
                bus.Start    = 1'b0;
                bus.Dividend = 16'h0000;
                bus.Divisor  = 16'h0000;
            end
            n++;
        end
        check({tag, "_latency"}, n, expLat);
        check({tag, "_busyCycles"}, busyCnt, expLat - 1);
        check({tag, "_done"}, {31'd0, bus.Done}, 32'd1);
        check({tag, "_busyInDone"}, {31'd0, bus.Busy}, 32'd0);
        check({tag, "_quotient"}, {16'd0, bus.Quotient}, {16'd0, expQ});
        check({tag, "_remainder"}, {16'd0, bus.Remainder}, {16'd0, expR});
        check({tag, "_divByZero"}, {31'd0, bus.DivByZero}, {31'd0, expDbz});
        if (checkPulseEnd) begin
            @(posedge clk);
            #1;
            check({tag, "_donePulseEnd"}, {31'd0, bus.Done}, 32'd0);
            check({tag, "_holdQuotient"}, {16'd0, bus.Quotient}, {16'd0, expQ});
        end
    endtask

    initial begin
        int doneSeen;
        bus.Start    = 1'b0;
        bus.Dividend = 16'h0000;
        bus.Divisor  = 16'h0000;

        // Reset state
        #12;
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_done", {31'd0, bus.Done}, 32'd0);
        check("rst_dbz", {31'd0, bus.DivByZero}, 32'd0);
        check("rst_quotient", {16'd0, bus.Quotient}, 32'd0);
        check("rst_remainder", {16'd0, bus.Remainder}, 32'd0);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Basic divides
        startOp(16'd100, 16'd7);
        check("d100_busyFirst", {31'd0, bus.Busy}, 32'd1);
        waitDone("d100_7", 16'd14, 16'd2, 1'b0, 17, 0, 1'b1);

        startOp(16'hFFFF, 16'h0001);
        waitDone("dFFFF_1", 16'hFFFF, 16'h0000, 1'b0, 17, 0, 1'b1);

        startOp(16'h8000, 16'hFFFF);
        waitDone("d8000_FFFF", 16'h0000, 16'h8000, 1'b0, 17, 0, 1'b1);

        // Divide by zero, then a valid divide clears the flag on acceptance
        startOp(16'd5, 16'd0);
        waitDone("d5_0", 16'hFFFF, 16'd5, 1'b1, 1, 0, 1'b1);
        startOp(16'd100, 16'd7);
        check("dbz_clearOnAccept", {31'd0, bus.DivByZero}, 32'd0);
        waitDone("d100_7_after", 16'd14, 16'd2, 1'b0, 17, 0, 1'b1);

        // Start pulsed mid-RUN with other operands is ignored
        startOp(16'd1000, 16'd33);
        waitDone("d1000_33", 16'd30, 16'd10, 1'b0, 17, 5, 1'b1);

        // Reset in cycle 8 of a divide aborts it
        startOp(16'd500, 16'd7);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("abort_busyBefore", {31'd0, bus.Busy}, 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.Busy}, 32'd0);
        check("abort_quotient", {16'd0, bus.Quotient}, 32'd0);
        check("abort_remainder", {16'd0, bus.Remainder}, 32'd0);
        check("abort_done", {31'd0, bus.Done}, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        doneSeen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) doneSeen++;
        end
        check("abort_noDone", doneSeen, 0);
        startOp(16'd9, 16'd3);
        waitDone("d9_3", 16'd3, 16'd0, 1'b0, 17, 0, 1'b1);

        // Start held high: 200/9 then 17/17 back-to-back
        bus.Start    = 1'b1;
        bus.Dividend = 16'd200;
        bus.Divisor  = 16'd9;
        @(posedge clk);
        #1;
        bus.Dividend = 16'd17;
        bus.Divisor  = 16'd17;
        waitDone("b2b_first", 16'd22, 16'd2, 1'b0, 17, 0, 1'b0);
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        check("b2b_busyAgain", {31'd0, bus.Busy}, 32'd1);
        check("b2b_doneLow", {31'd0, bus.Done}, 32'd0);
        waitDone("b2b_second", 16'd1, 16'd0, 1'b0, 17, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
